// File: rtl/video_timing_pipe.sv
// Programmable video timing generator: h/v counters, framebuffer request decode, and a
// LAT-deep alignment pipe so sync/de/rgb leave mutually aligned for the TMDS serialiser.
module video_timing_pipe #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 8,
   parameter int LAT      = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int X_W     = $clog2(H_TOTAL),
   localparam int Y_W     = $clog2(V_TOTAL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   output logic [X_W-1:0]       x,
   output logic [Y_W-1:0]       y,
   output logic                 req,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [3*COLOR_W-1:0] rgb_out,
   output logic                 line_start,
   output logic                 frame_start
);

   if (H_ACTIVE <= 0 || V_ACTIVE <= 0 || H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_geom
      $error("video_timing_pipe: active and sync widths must be positive");
   end
   if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
      $error("video_timing_pipe: porches must be non-negative");
   end
   if (LAT < 0 || LAT > 15 || COLOR_W < 1 || COLOR_W > 10) begin : g_bad_cfg
      $error("video_timing_pipe: LAT must be 0..15 and COLOR_W 1..10");
   end

   localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

   logic [X_W-1:0] h;
   logic [Y_W-1:0] v;
   logic           h_wrap;
   logic           v_wrap;
   logic           hs_raw;
   logic           vs_raw;
   logic [2:0]     cur;
   logic [2:0]     tap;

   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         h <= H_LAST;
         v <= V_LAST;
      end else if (ce) begin
         h <= h_wrap ? '0 : h + X_W'(1);
         if (h_wrap) v <= v_wrap ? '0 : v + Y_W'(1);
      end
   end

   // Pulses describe the counter state just entered, so they are cleared on any non-ce clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= ce & h_wrap;
         frame_start <= ce & h_wrap & v_wrap;
      end
   end

   assign x      = h;
   assign y      = v;
   assign req    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
   assign hs_raw = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_raw = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
   assign cur    = {req, hs_raw, vs_raw};

   if (LAT == 0) begin : g_no_dly
      assign tap = cur;
   end else begin : g_dly
      logic [2:0] sr [LAT];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
         end else if (ce) begin
            sr[0] <= cur;
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
         end
      end
      assign tap = sr[LAT-1];
   end

   // rgb_in arrives for the request that is just now leaving the delay line.
   always_ff @(posedge clk) begin
      if (rst) begin
         de      <= 1'b0;
         hsync   <= ~HS_POL;
         vsync   <= ~VS_POL;
         rgb_out <= '0;
      end else if (ce) begin
         de      <= tap[2];
         hsync   <= tap[1] ^ ~HS_POL;
         vsync   <= tap[0] ^ ~VS_POL;
         rgb_out <= tap[2] ? rgb_in : '0;
      end
   end

endmodule

// File: tb/tb_video_timing_pipe.sv
// Directed bench for video_timing_pipe on a tiny 8x6 raster with LAT=2; expected aligned
// outputs are queued when each counter state is produced and popped LAT+1 ticks later.
module tb_video_timing_pipe;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [26:0] IDLE = {1'b0, 1'b1, 1'b1, 24'h0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic [23:0] rgb_in = '0;
   logic [2:0]  x;
   logic [2:0]  y;
   logic        req;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [23:0] rgb_out;
   logic        line_start;
   logic        frame_start;

   video_timing_pipe #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .x(x), .y(y), .req(req), .rgb_in(rgb_in),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out),
      .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [26:0] exp_q[$];
   logic [26:0] last_exp;
   int          mh;
   int          mv;
   bit          ff_mode = 1'b0;
   logic [23:0] p0, p1, p2;

   function automatic logic [23:0] pix(int h, int v);
      if (ff_mode) return 24'hFFFFFF;
      return {8'(h), 8'(v), 8'hA5};
   endfunction

   function automatic logic [26:0] model_out(int h, int v);
      logic de_e, hs_a, vs_a;
      de_e = (h < HA) && (v < VA);
      hs_a = (h >= HA + HF) && (h < HA + HF + HS);
      vs_a = (v >= VA + VF) && (v < VA + VF + VS);
      return {de_e, ~hs_a, ~vs_a, de_e ? pix(h, v) : 24'h0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
      end
   endtask

   task automatic check_outs(input logic [26:0] e);
      chk("de", 32'(de), 32'(e[26]));
      chk("hsync", 32'(hsync), 32'(e[25]));
      chk("vsync", 32'(vsync), 32'(e[24]));
      chk("rgb_out", 32'(rgb_out), 32'(e[23:0]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ce  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_outs(IDLE);
         chk("rst_x", 32'(x), 32'(HT - 1));
         chk("rst_y", 32'(y), 32'(VT - 1));
         chk("rst_req", 32'(req), 32'd0);
         chk("rst_line_start", 32'(line_start), 32'd0);
         chk("rst_frame_start", 32'(frame_start), 32'd0);
      end
      mh = HT - 1;
      mv = VT - 1;
      exp_q.delete();
      repeat (3) exp_q.push_back(IDLE);
      last_exp = IDLE;
      p0 = pix(mh, mv);
      p1 = '0;
      p2 = '0;
      rgb_in = p2;
      rst = 1'b0;
   endtask

   task automatic tick(input bit ce_v);
      logic [26:0] e;
      ce = ce_v;
      @(posedge clk);
      #1;
      if (ce_v) begin
         mh = (mh == HT - 1) ? 0 : mh + 1;
         if (mh == 0) mv = (mv == VT - 1) ? 0 : mv + 1;
         exp_q.push_back(model_out(mh, mv));
         e = exp_q.pop_front();
         last_exp = e;
         p2 = p1;
         p1 = p0;
         p0 = pix(mh, mv);
         rgb_in = p2;
         chk("line_start", 32'(line_start), 32'(mh == 0));
         chk("frame_start", 32'(frame_start), 32'(mh == 0 && mv == 0));
      end else begin
         e = last_exp;
         chk("line_start_hold", 32'(line_start), 32'd0);
         chk("frame_start_hold", 32'(frame_start), 32'd0);
      end
      check_outs(e);
      chk("x", 32'(x), 32'(mh));
      chk("y", 32'(y), 32'(mv));
      chk("req", 32'(req), 32'((mh < HA) && (mv < VA)));
   endtask

   initial begin
      // Reset, then two full frames with ce held high.
      do_reset();
      repeat (2 * HT * VT) tick(1'b1);

      // ce asserted one clock in three for a full frame.
      repeat (HT * VT) begin
         tick(1'b1);
         tick(1'b0);
         tick(1'b0);
      end

      // Reset in the middle of the active area at (2,1).
      for (int i = 0; i < 2 * HT * VT; i++) begin
         if (mh == 2 && mv == 1) break;
         tick(1'b1);
      end
      chk("reached_mid_active", 32'(mh == 2 && mv == 1), 32'd1);
      do_reset();
      repeat (HT * 2 + 4) tick(1'b1);

      // Saturated pixel input: rgb_out must still be zero outside de.
      ff_mode = 1'b1;
      repeat (HT * VT + 3) tick(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
